// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Signed overflow from operand and result sign bits; subtract flips B's sign.
  function automatic logic ovf_flag(input logic mode, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    logic same_sign;
    same_sign = (mode == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
    return same_sign && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple of full-adder or full-subtractor cells.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             mode,
  input  logic             cbin,
  output logic [DIGIT-1:0] r,
  output logic             cbout
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    r      = '0;
    w_c[0] = cbin;
    for (int i = 0; i < DIGIT; i++) begin
      r[i] = a[i] ^ b[i] ^ w_c[i];
      if (mode == MODE_SUB) begin
        w_c[i+1] = (~a[i] & (b[i] ^ w_c[i])) | (b[i] & w_c[i]);
      end else begin
        w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
    end
  end

  assign cbout = w_c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock
// with the carry/borrow registered between digits.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cbin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cbout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_mode;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cbout;
  logic             r_ovf;

  logic [31:0]      w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_r_dig;
  logic [WIDTH-1:0] w_slot;
  logic [WIDTH-1:0] w_r_pos;
  logic             w_c_nxt;
  logic             w_last;
  logic             w_accept;

  // Current digit slice, selected by shifting rather than variable part-select.
  assign w_base   = 32'(r_cnt) * DIGIT;
  assign w_a_dig  = DIGIT'(r_a >> w_base);
  assign w_b_dig  = DIGIT'(r_b >> w_base);
  assign w_slot   = WIDTH'({DIGIT{1'b1}}) << w_base;
  assign w_r_pos  = WIDTH'(w_r_dig) << w_base;
  assign w_last   = (r_cnt == CW'(NDIG - 1));
  assign w_accept = start && (r_state != ST_RUN);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (w_a_dig),
    .b     (w_b_dig),
    .mode  (r_mode),
    .cbin  (r_c),
    .r     (w_r_dig),
    .cbout (w_c_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, digit datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_mode  <= MODE_ADD;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cbout <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a    <= op_a;
        r_b    <= op_b;
        r_mode <= mode;
        r_c    <= cbin;
        r_cnt  <= '0;
        r_res  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_res <= (r_res & ~w_slot) | w_r_pos;
        r_c   <= w_c_nxt;
        if (w_last) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_cbout <= w_c_nxt;
          r_ovf   <= ovf_flag(r_mode, r_a[WIDTH-1], r_b[WIDTH-1], w_r_dig[DIGIT-1]);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_res;
  assign cbout  = r_cbout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three parameterisations against an
// arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // WIDTH=16 DIGIT=4
  logic        st16, md16, ci16, bsy16, dn16, co16, ov16;
  logic [15:0] a16, b16, r16;
  // WIDTH=8 DIGIT=1
  logic        sts8, mds8, cis8, bsys8, dns8, cos8, ovs8;
  logic [7:0]  as8, bs8, rs8;
  // WIDTH=8 DIGIT=8
  logic        stp8, mdp8, cip8, bsyp8, dnp8, cop8, ovp8;
  logic [7:0]  ap8, bp8, rp8;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .mode(md16), .op_a(a16), .op_b(b16),
    .cbin(ci16), .busy(bsy16), .done(dn16), .result(r16), .cbout(co16), .ovf(ov16));

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(sts8), .mode(mds8), .op_a(as8), .op_b(bs8),
    .cbin(cis8), .busy(bsys8), .done(dns8), .result(rs8), .cbout(cos8), .ovf(ovs8));

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_p8 (
    .clk(clk), .rst_n(rst_n), .start(stp8), .mode(mdp8), .op_a(ap8), .op_b(bp8),
    .cbin(cip8), .busy(bsyp8), .done(dnp8), .result(rp8), .cbout(cop8), .ovf(ovp8));

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic        cin;
    logic [15:0] r;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic drive(input int sel, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic cin);
    case (sel)
      0: begin st16 = s; a16 = a; b16 = b; md16 = m; ci16 = cin; end
      1: begin sts8 = s; as8 = a[7:0]; bs8 = b[7:0]; mds8 = m; cis8 = cin; end
      default: begin stp8 = s; ap8 = a[7:0]; bp8 = b[7:0]; mdp8 = m; cip8 = cin; end
    endcase
  endtask

  // {busy, done, cbout, ovf, result[15:0]}
  function automatic logic [19:0] rd(input int sel);
    case (sel)
      0:       rd = {bsy16, dn16, co16, ov16, r16};
      1:       rd = {bsys8, dns8, cos8, ovs8, 8'h00, rs8};
      default: rd = {bsyp8, dnp8, cop8, ovp8, 8'h00, rp8};
    endcase
  endfunction

  function automatic int ndig(input int sel);
    case (sel)
      0:       ndig = 4;
      1:       ndig = 8;
      default: ndig = 1;
    endcase
  endfunction

  function automatic int wid(input int sel);
    wid = (sel == 0) ? 16 : 8;
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic m, input logic cin,
                                output logic [15:0] r, output logic co, output logic ov);
    longint full, half, ua, ub, ci, s, sa, sb, ss;
    full = longint'(1) << w;
    half = full / 2;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    ci = longint'(cin);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (m) begin
      s  = ua - ub - ci;
      co = (ua < ub + ci);
      ss = sa - sb - ci;
    end else begin
      s  = ua + ub + ci;
      co = (s >= full);
      ss = sa + sb + ci;
    end
    r  = 16'(s & (full - 1));
    ov = (ss >= half) || (ss < -half);
  endfunction

  task automatic drive_idle_random(input int sel);
    drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // One complete operation with latency, busy, result and hold checks.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic cin, input bit poke, input string tag,
                       output logic [15:0] ro, output logic coo, output logic ovo);
    logic [19:0] o;
    logic [15:0] er;
    logic        ec, eo;
    int          lat, nd;
    nd = ndig(sel);
    model(wid(sel), a, b, m, cin, er, ec, eo);
    drive(sel, 1'b1, a, b, m, cin);
    @(posedge clk); #1;
    drive_idle_random(sel);
    o = rd(sel);
    nvec++;
    if (o[19] !== 1'b1 || o[18] !== 1'b0) begin
      nerr++;
      $display("FAIL %s accept: busy/done got %b%b want 10", tag, o[19], o[18]);
    end
    lat = 0;
    for (int k = 1; k <= nd + 3; k++) begin
      @(posedge clk); #1;
      o = rd(sel);
      if (o[18] === 1'b1) begin
        lat = k;
        break;
      end
      nvec++;
      if (o[19] !== 1'b1) begin
        nerr++;
        $display("FAIL %s busy cycle %0d: got %b want 1", tag, k, o[19]);
      end
      if (poke && nd >= 3 && k == 1)
        drive(sel, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else if (poke && nd >= 3 && k == 2)
        drive_idle_random(sel);
    end
    nvec++;
    if (lat != nd) begin
      nerr++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, nd);
    end
    nvec++;
    if (o[15:0] !== er || o[17] !== ec || o[16] !== eo || o[19] !== 1'b0) begin
      nerr++;
      $display("FAIL %s result: got r=%h co=%b ov=%b busy=%b want r=%h co=%b ov=%b busy=0",
               tag, o[15:0], o[17], o[16], o[19], er, ec, eo);
    end
    ro = o[15:0]; coo = o[17]; ovo = o[16];
    @(posedge clk); #1;
    o = rd(sel);
    nvec++;
    if (o[18] !== 1'b0 || o[19] !== 1'b0 || o[15:0] !== er || o[17] !== ec || o[16] !== eo) begin
      nerr++;
      $display("FAIL %s hold: got done=%b busy=%b r=%h co=%b ov=%b want done=0 busy=0 r=%h co=%b ov=%b",
               tag, o[18], o[19], o[15:0], o[17], o[16], er, ec, eo);
    end
  endtask

  task automatic test_reset();
    logic [19:0] o;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      o = rd(s);
      nvec++;
      if (o !== 20'h0) begin
        nerr++;
        $display("FAIL reset inst%0d: got %h want 00000", s, o);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    o = rd(0);
    nvec++;
    if (o !== 20'h0) begin
      nerr++;
      $display("FAIL post_reset idle: got %h want 00000", o);
    end
  endtask

  task automatic test_directed();
    vec_t        tbl[8];
    logic [15:0] ro;
    logic        co, ov;
    tbl[0] = '{0, 16'h1234, 16'h0235, 1'b1, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    tbl[1] = '{0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[3] = '{0, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[4] = '{0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{1, 16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{2, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].cin, 1'b0, "directed", ro, co, ov);
      nvec++;
      if (ro !== tbl[i].r || co !== tbl[i].co || ov !== tbl[i].ov) begin
        nerr++;
        $display("FAIL directed[%0d]: got r=%h co=%b ov=%b want r=%h co=%b ov=%b",
                 i, ro, co, ov, tbl[i].r, tbl[i].co, tbl[i].ov);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ro;
    logic        co, ov;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 15; i++)
        do_op(s, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, "random",
              ro, co, ov);
  endtask

  task automatic test_start_ignored();
    logic [15:0] ro;
    logic        co, ov;
    do_op(0, 16'h1234, 16'h0235, 1'b1, 1'b0, 1'b1, "ignore_dir", ro, co, ov);
    for (int i = 0; i < 4; i++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, "ignore_rnd",
            ro, co, ov);
  endtask

  task automatic test_back_to_back();
    logic [19:0] o;
    logic [15:0] a1, b1, a2, b2, er;
    logic        m1, c1, m2, c2, ec, eo;
    int          lat;
    a1 = 16'($urandom); b1 = 16'($urandom); m1 = 1'($urandom); c1 = 1'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); m2 = 1'($urandom); c2 = 1'($urandom);
    drive(0, 1'b1, a1, b1, m1, c1);
    @(posedge clk); #1;
    drive_idle_random(0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (dn16 === 1'b1) begin lat = k; break; end
    end
    nvec++;
    if (lat != 4) begin
      nerr++;
      $display("FAIL b2b first latency: got %0d want 4", lat);
    end
    model(16, a1, b1, m1, c1, er, ec, eo);
    o = rd(0);
    nvec++;
    if (o[15:0] !== er || o[17] !== ec || o[16] !== eo) begin
      nerr++;
      $display("FAIL b2b first result: got r=%h co=%b ov=%b want r=%h co=%b ov=%b",
               o[15:0], o[17], o[16], er, ec, eo);
    end
    drive(0, 1'b1, a2, b2, m2, c2);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      o = rd(0);
      if (k == 1) begin
        drive_idle_random(0);
        nvec++;
        if (o[19] !== 1'b1 || o[18] !== 1'b0 || o[15:0] !== 16'h0) begin
          nerr++;
          $display("FAIL b2b accept: got busy=%b done=%b r=%h want busy=1 done=0 r=0000",
                   o[19], o[18], o[15:0]);
        end
      end
      if (o[18] === 1'b1) begin lat = k; break; end
    end
    nvec++;
    if (lat != 5) begin
      nerr++;
      $display("FAIL b2b done spacing: got %0d want 5", lat);
    end
    model(16, a2, b2, m2, c2, er, ec, eo);
    nvec++;
    if (o[15:0] !== er || o[17] !== ec || o[16] !== eo) begin
      nerr++;
      $display("FAIL b2b second result: got r=%h co=%b ov=%b want r=%h co=%b ov=%b",
               o[15:0], o[17], o[16], er, ec, eo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [19:0] o;
    logic [15:0] ro;
    logic        co, ov;
    bit          saw_done;
    drive(0, 1'b1, 16'h1234, 16'h0235, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_idle_random(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    o = rd(0);
    nvec++;
    if (o[19] !== 1'b1 || o[15:0] !== 16'h00FF) begin
      nerr++;
      $display("FAIL midrun partial: got busy=%b r=%h want busy=1 r=00ff", o[19], o[15:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    o = rd(0);
    nvec++;
    if (o !== 20'h0) begin
      nerr++;
      $display("FAIL async reset: got %h want 00000", o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (dn16 !== 1'b0 || bsy16 !== 1'b0) saw_done = 1'b1;
    end
    nvec++;
    if (saw_done) begin
      nerr++;
      $display("FAIL after reset: got activity=1 want 0");
    end
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, "post_reset_op", ro, co, ov);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
